// File: rtl/mod_dec_shifter_pkg.sv
// Shared AES datapath types: the 16-byte state and the elastic-buffer FSM encoding.
`default_nettype none

package aes_pkg;

  localparam int N = 16;

  typedef logic [N-1:0][7:0] state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

`default_nettype wire

// File: rtl/mod_dec_shifter_if.sv
// Valid/ready stream bundle for the InvShiftRows stage, input and output sides.
`default_nettype none

interface mod_dec_shifter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in;
  logic   in_last;
  logic   out_valid;
  logic   out_ready;
  state_t out;
  logic   out_last;

  modport slave (
    input  in_valid, in, in_last, out_ready,
    output in_ready, out_valid, out, out_last
  );

  modport master (
    output in_valid, in, in_last, out_ready,
    input  in_ready, out_valid, out, out_last
  );

endinterface

`default_nettype wire

// File: rtl/mod_dec_invshift_comb.sv
// Pure combinational AES InvShiftRows: row r of the state rotates right by r bytes.
`default_nettype none

module mod_dec_invshift_comb
  import aes_pkg::*;
(
  input  state_t state_i,
  output state_t state_o
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign state_o[4*r + c] = state_i[4*r + ((c - r + 4) % 4)];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_dec_shifter.sv
// InvShiftRows pipeline stage: permutes on entry, then a 2-entry skid buffer
// so in_ready is a function of occupancy only.
`default_nettype none

module mod_dec_shifter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mod_dec_shifter_if.slave   bus
);

  buf_state_e state_q, state_d;
  state_t     out_q, out_d;
  state_t     skid_q, skid_d;
  logic       out_last_q, out_last_d;
  logic       skid_last_q, skid_last_d;

  state_t     perm;
  logic       in_ready;
  logic       out_valid;
  logic       in_xfer;
  logic       out_xfer;

  mod_dec_invshift_comb u_invshift (
    .state_i (bus.in),
    .state_o (perm)
  );

  // rst_n gating keeps in_ready low during reset and high right after release.
  assign in_ready  = rst_n & (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_q;
  assign bus.out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    skid_d      = skid_q;
    skid_last_d = skid_last_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          out_d      = perm;
          out_last_d = bus.in_last;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_d      = perm;
          out_last_d = bus.in_last;
        end else if (in_xfer) begin
          skid_d      = perm;
          skid_last_d = bus.in_last;
          state_d     = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          out_d      = skid_q;
          out_last_d = skid_last_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      skid_q      <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      skid_q      <= skid_d;
      skid_last_q <= skid_last_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_dec_shifter.sv
// Directed bench for mod_dec_shifter: permutation, round trip, streaming,
// backpressure, simultaneous transfer and mid-operation reset.
`default_nettype none

module tb_mod_dec_shifter;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mod_dec_shifter_if bus ();

  mod_dec_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Forward ShiftRows: row r rotates left by r. Undoing it must give back the original.
  function automatic state_t enc(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[4*r + c] = s[4*r + ((c + r) % 4)];
    return o;
  endfunction

  function automatic state_t rnd_state();
    state_t s;
    for (int i = 0; i < 16; i++) s[i] = 8'($urandom_range(0, 255));
    return s;
  endfunction

  task automatic chk_st(input string tag, input state_t obs, input state_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Upstream must hold `in` while stalled.
  state_t hold_in;
  logic   hold_pend = 1'b0;
  always @(posedge clk) begin
    if (hold_pend && bus.in_valid) begin
      assert (bus.in === hold_in) else begin
        bad++;
        $error("FAIL in_hold observed=%h expected=%h", bus.in, hold_in);
      end
    end
    hold_pend = bus.in_valid && !bus.in_ready;
    hold_in   = bus.in;
  end

  task automatic send(input state_t s, input logic last);
    bus.in       = enc(s);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
  endtask

  task automatic stream(input int n, input bit rnd);
    state_t s, prev;
    logic   prev_last;
    prev      = '0;
    prev_last = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk_bit("strm_valid", bus.out_valid, 1'b1);
        chk_bit("strm_ready", bus.in_ready, 1'b1);
        chk_st ("strm_data",  bus.out, prev);
        chk_bit("strm_last",  bus.out_last, prev_last);
      end
      if (rnd) s = rnd_state();
      else for (int i = 0; i < 16; i++) s[i] = 8'(k * 16 + i);
      send(s, !rnd && (k == n - 1));
      prev      = s;
      prev_last = bus.in_last;
    end
    @(negedge clk);
    chk_bit("strm_valid_end", bus.out_valid, 1'b1);
    chk_st ("strm_data_end",  bus.out, prev);
    chk_bit("strm_last_end",  bus.out_last, prev_last);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    chk_bit("strm_drained", bus.out_valid, 1'b0);
  endtask

  state_t a, b, c, d, e, f, g, exp_basic, ramp;
  logic [7:0] basic_tbl [16];

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_bit("rst_in_ready",  bus.in_ready,  1'b0);
    chk_bit("rst_out_valid", bus.out_valid, 1'b0);
    chk_st ("rst_out",       bus.out,       '0);
    chk_bit("rst_out_last",  bus.out_last,  1'b0);
    rst_n = 1'b1;
    #1;
    chk_bit("rel_in_ready", bus.in_ready, 1'b1);

    // Basic permutation with in[i] = i
    basic_tbl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                  8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};
    for (int i = 0; i < 16; i++) begin
      exp_basic[i] = basic_tbl[i];
      ramp[i]      = 8'(i);
    end
    @(negedge clk);
    bus.in       = ramp;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk_bit("basic_valid", bus.out_valid, 1'b1);
    chk_st ("basic_out",   bus.out, exp_basic);
    chk_bit("basic_ready", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_bit("basic_drain", bus.out_valid, 1'b0);

    // Streaming with last tag on the final block, then random round trip
    stream(64, 1'b0);
    stream(1000, 1'b1);

    // Backpressure: A, B fill the buffer, C stalls
    a = rnd_state(); b = rnd_state(); c = rnd_state();
    bus.out_ready = 1'b0;
    send(a, 1'b0);
    @(negedge clk);
    chk_bit("bp_ready_a", bus.in_ready, 1'b1);
    chk_st ("bp_out_a",   bus.out, a);
    send(b, 1'b1);
    @(negedge clk);
    chk_bit("bp_ready_b", bus.in_ready, 1'b0);
    chk_st ("bp_hold_a",  bus.out, a);
    send(c, 1'b0);
    @(negedge clk);
    chk_bit("bp_ready_c",  bus.in_ready, 1'b0);
    chk_st ("bp_stable_a", bus.out, a);
    chk_bit("bp_last_a",   bus.out_last, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_bit("bp_valid_b", bus.out_valid, 1'b1);
    chk_st ("bp_out_b",   bus.out, b);
    chk_bit("bp_last_b",  bus.out_last, 1'b1);
    chk_bit("bp_ready_1", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_bit("bp_valid_c", bus.out_valid, 1'b1);
    chk_st ("bp_out_c",   bus.out, c);
    chk_bit("bp_last_c",  bus.out_last, 1'b0);
    @(negedge clk);
    chk_bit("bp_empty", bus.out_valid, 1'b0);

    // Simultaneous in/out transfer while holding one entry
    d = rnd_state(); e = rnd_state();
    bus.out_ready = 1'b0;
    send(d, 1'b0);
    @(negedge clk);
    chk_st("sim_out_d", bus.out, d);
    send(e, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_bit("sim_valid", bus.out_valid, 1'b1);
    chk_bit("sim_ready", bus.in_ready, 1'b1);
    chk_st ("sim_out_e", bus.out, e);
    chk_bit("sim_last_e", bus.out_last, 1'b1);
    @(negedge clk);
    chk_bit("sim_single", bus.out_valid, 1'b0);

    // Asynchronous reset while full
    f = rnd_state(); g = rnd_state();
    bus.out_ready = 1'b0;
    send(f, 1'b1);
    @(negedge clk);
    send(g, 1'b0);
    @(negedge clk);
    chk_bit("mr_full",   bus.in_ready, 1'b0);
    chk_st ("mr_out_f",  bus.out, f);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_bit("mr_valid0", bus.out_valid, 1'b0);
    chk_st ("mr_out0",   bus.out, '0);
    chk_bit("mr_last0",  bus.out_last, 1'b0);
    chk_bit("mr_ready0", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_bit("mr_ready1", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_bit("mr_no_stale", bus.out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_dec_shifter.md
# mod_dec_shifter

Pipelined InvShiftRows stage for the AES-256 decryption datapath. It accepts one 16-byte state per valid/ready transfer and applies the inverse row rotation. It returns the result through a 2-entry elastic buffer, so the stage sustains one block per cycle under backpressure. It sits between the decryption AddRoundKey/InvMixColumns stage and the InvSubBytes stage, and is the decrypt-side counterpart of mod_enc_shifter.

## Interface
- N, 16: bytes per AES state (fixed; not overridable)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream holds a valid state on `in`
- in_ready  output  1  stage can accept a state this cycle
- in  input  [N-1:0][7:0]  state bytes; byte index i = 4*row + col
- in_last  input  1  sideband tag (final round), carried with the data
- out_valid  output  1  `out` holds a valid state
- out_ready  input  1  downstream accepts this cycle
- out  output  [N-1:0][7:0]  inverse-shifted state, same indexing
- out_last  output  1  sideband tag aligned with `out`

## Operation
- Permutation: out[4r+c] = in[4r + ((c - r) mod 4)], for r,c in 0..3.
  - Row 0 unchanged.
  - Row 1 rotates right by 1.
  - Row 2 rotates by 2.
  - Row 3 rotates right by 3.
- Permutation is applied combinationally on the input side, before the buffer. Buffered data is already permuted.
- Transfer rule: a transfer occurs on a rising clk edge when valid && ready on that port.
- Buffer FSM, 2 bits:
  - EMPTY: no entries. out_valid=0, in_ready=1.
  - ONE: output register valid. out_valid=1, in_ready=1.
  - TWO: output register and skid register valid. out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + in xfer -> ONE.
  - ONE + in xfer, no out xfer -> TWO (input goes to skid).
  - ONE + out xfer, no in xfer -> EMPTY.
  - ONE + both -> ONE (output register reloads from input).
  - TWO + out xfer -> ONE (skid moves to output register).
  - TWO with no out xfer holds.
- in_ready depends only on state (registered), never combinationally on out_ready.
- in_last travels with its data through both registers, bit-exact.
- Data ordering is strictly FIFO. No data is dropped or duplicated.
- While out_valid=1 and out_ready=0, `out` and out_last are stable.

## Timing
- Latency is 1 cycle: data accepted at edge k is presented on `out` after edge k, if the buffer was EMPTY or draining.
- Throughput is 1 block/cycle while out_ready stays high.
- Reset (rst_n low, asynchronous):
  - state=EMPTY, out_valid=0, out=0, out_last=0, skid contents=0.
  - in_ready=0 while rst_n is low. in_ready=1 from deassertion onward.
- Reset mid-operation: all buffered blocks are discarded. No out_valid pulse follows deassertion until a new input transfer occurs.
- Simultaneous in and out transfers in ONE: occupancy stays 1 and the new data replaces the output.
- Upstream must hold `in` stable while in_valid=1 && in_ready=0. The bench checks this as an assertion.

## Structure
- Shared package aes_pkg holds:
  - typedef state_t = logic [15:0][7:0];
  - the buffer FSM enum buf_state_e {EMPTY, ONE, TWO}.
- Sub-module mod_dec_invshift_comb is the pure combinational permutation (state_t in/out). The verification suite reuses it as a reference and for round-trip tests against mod_enc_shifter.
- Top level mod_dec_shifter contains the FSM, the output register and the skid register.

## Test plan
- Basic permutation: reset, then one transfer with in[i]=i (0x00..0x0F).
  - Next cycle out = {00,01,02,03, 07,04,05,06, 0A,0B,08,09, 0D,0E,0F,0C} (listed index 0..15), out_valid=1.
- Round trip: random state S through mod_enc_shifter then mod_dec_shifter -> out == S, for 1000 random states.
- Streaming: in_valid and out_ready held high for 64 consecutive states.
  - 64 outputs on 64 consecutive cycles, in order.
  - in_last on state 63 only -> out_last only on output 63.
- Backpressure: out_ready=0 while sending 3 states A, B, C.
  - A and B accepted; in_ready drops to 0 after B (state TWO); C is held.
  - Release out_ready -> outputs A, B, C in order, with no gaps once released.
- Simultaneous events: in ONE, assert in and out transfer on the same edge.
  - Occupancy stays ONE; out shows the new state next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously in TWO.
  - out_valid=0 and out=0 immediately, not at the next edge.
  - After release: in_ready=1, and no stale output ever appears.
